// File: rtl/usbls_pkg.sv
// Shared definitions for the USB low-speed receive token path: token PID
// codes, CRC5 constants, field geometry and the decoder FSM encoding.
package usbls_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;

    localparam logic [4:0] CRC5_POLY     = 5'b00101;
    localparam logic [4:0] CRC5_INIT     = 5'h1F;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

    // Bit counts used by the decoder bit counter.
    localparam logic [4:0] PID_BITS   = 5'd8;
    localparam logic [4:0] FIELD_BITS = 5'd11;
    localparam logic [4:0] BODY_BITS  = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PID  = 2'd1,
        ST_BODY = 2'd2,
        ST_DROP = 2'd3
    } rx_state_e;

    // One serial CRC5 step: shift left, fold in the polynomial on feedback.
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic din);
        logic fb;
        fb = c[4] ^ din;
        crc5_step = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    endfunction

    // True for the four token-class PID nibbles.
    function automatic logic is_token_pid(input logic [3:0] nib);
        case (nib)
            PID_OUT, PID_IN, PID_SETUP, PID_SOF: is_token_pid = 1'b1;
            default:                             is_token_pid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usbls_rx_crc5.sv
// Serial CRC5 over the token body. init (re)loads the seed and wins over en;
// en advances the register by one received bit.
module usbls_rx_crc5
    import usbls_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       en,
    input  logic       din,
    output logic [4:0] crc
);

    logic [4:0] crc_d;
    logic [4:0] crc_q;

    // Next CRC value: seed on init, step on en, otherwise hold.
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC5_INIT;
        end else if (en) begin
            crc_d = crc5_step(crc_q, din);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register, seeded value out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC5_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usbls_rx_token_decoder.sv
// USB low-speed receive token decoder. Consumes the unstuffed LSB-first bit
// stream, assembles PID, the 11-bit ADDR/ENDP (or SOF frame) field and CRC5,
// checks PID complement, CRC residual and body length, and publishes one
// registered result per token packet the cycle after EOP.
module usbls_rx_token_decoder
    import usbls_pkg::*;
#(
    parameter bit ADDR_FILTER = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_sop,
    input  logic        rx_bit_valid,
    input  logic        rx_bit,
    input  logic        rx_eop,
    input  logic [6:0]  dev_addr,
    output logic        tok_valid,
    output logic [3:0]  tok_pid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic [10:0] tok_frame,
    output logic        tok_match,
    output logic        tok_crc_err,
    output logic        tok_pid_err,
    output logic        tok_len_err
);

    rx_state_e   state_q, state_d, state_eff;
    logic [4:0]  cnt_q, cnt_d, cnt_eff;
    logic [7:0]  pid_q, pid_d, pid_eff;
    logic        pid_err_q, pid_err_d, pid_err_eff;
    logic        len_q, len_d, len_eff;
    logic [10:0] field_q, field_d, field_eff;

    logic        crc_en_s;
    logic [4:0]  crc_s;
    logic [4:0]  crc_eff;
    logic        emit_s;
    logic        len_err_s;
    logic        crc_err_s;
    logic        match_s;

    logic        tok_valid_q, tok_valid_d;
    logic [3:0]  tok_pid_q, tok_pid_d;
    logic [10:0] tok_field_q, tok_field_d;
    logic        tok_match_q, tok_match_d;
    logic        tok_crc_err_q, tok_crc_err_d;
    logic        tok_pid_err_q, tok_pid_err_d;
    logic        tok_len_err_q, tok_len_err_d;

    usbls_rx_crc5 u_crc5 (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (rx_sop),
        .en    (crc_en_s),
        .din   (rx_bit),
        .crc   (crc_s)
    );

    // Bit consumption for the current state; the *_eff values describe the
    // packet after this cycle's bit, before EOP or SOP are considered.
    always_comb begin
        state_eff   = state_q;
        cnt_eff     = cnt_q;
        pid_eff     = pid_q;
        pid_err_eff = pid_err_q;
        len_eff     = len_q;
        field_eff   = field_q;
        crc_en_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_eff = ST_IDLE;
            end
            ST_PID: begin
                if (rx_bit_valid) begin
                    pid_eff = {rx_bit, pid_q[7:1]};
                    if (cnt_q == (PID_BITS - 5'd1)) begin
                        cnt_eff     = 5'd0;
                        pid_err_eff = (pid_eff[7:4] != ~pid_eff[3:0]);
                        state_eff   = is_token_pid(pid_eff[3:0]) ? ST_BODY : ST_DROP;
                    end else begin
                        cnt_eff = cnt_q + 5'd1;
                    end
                end else begin
                    state_eff = ST_PID;
                end
            end
            ST_BODY: begin
                if (rx_bit_valid) begin
                    if (cnt_q == BODY_BITS) begin
                        // Bit 17: too long, result is still owed at EOP.
                        len_eff   = 1'b1;
                        state_eff = ST_DROP;
                    end else begin
                        crc_en_s = 1'b1;
                        cnt_eff  = cnt_q + 5'd1;
                        if (cnt_q < FIELD_BITS) begin
                            field_eff[cnt_q[3:0]] = rx_bit;
                        end else begin
                            field_eff = field_q;
                        end
                    end
                end else begin
                    state_eff = ST_BODY;
                end
            end
            ST_DROP: begin
                state_eff = ST_DROP;
            end
            default: begin
                state_eff = ST_IDLE;
            end
        endcase
    end

    // EOP handling, result computation and SOP restart.
    always_comb begin
        crc_eff   = crc_en_s ? crc5_step(crc_s, rx_bit) : crc_s;
        len_err_s = len_eff | (cnt_eff != BODY_BITS);
        crc_err_s = len_err_s | (crc_eff != CRC5_RESIDUAL);
        match_s   = ADDR_FILTER ? (field_eff[6:0] == dev_addr) : 1'b1;
        emit_s    = 1'b0;
        state_d   = state_eff;
        cnt_d     = cnt_eff;
        pid_d     = pid_eff;
        pid_err_d = pid_err_eff;
        len_d     = len_eff;
        field_d   = field_eff;
        if (rx_eop) begin
            case (state_eff)
                ST_BODY: emit_s = 1'b1;
                ST_DROP: emit_s = len_eff;
                default: emit_s = 1'b0;
            endcase
            state_d = ST_IDLE;
        end else begin
            state_d = state_eff;
        end
        if (rx_sop) begin
            state_d   = ST_PID;
            cnt_d     = 5'd0;
            pid_d     = 8'h00;
            pid_err_d = 1'b0;
            len_d     = 1'b0;
            field_d   = 11'd0;
        end else begin
            cnt_d = cnt_eff;
        end
    end

    // Output registers: pulse valid on emit, fields hold between results.
    always_comb begin
        tok_valid_d   = emit_s;
        tok_pid_d     = tok_pid_q;
        tok_field_d   = tok_field_q;
        tok_match_d   = tok_match_q;
        tok_crc_err_d = tok_crc_err_q;
        tok_pid_err_d = tok_pid_err_q;
        tok_len_err_d = tok_len_err_q;
        if (emit_s) begin
            tok_pid_d     = pid_eff[3:0];
            tok_field_d   = field_eff;
            tok_match_d   = match_s;
            tok_crc_err_d = crc_err_s;
            tok_pid_err_d = pid_err_eff;
            tok_len_err_d = len_err_s;
        end else begin
            tok_valid_d = 1'b0;
        end
    end

    // Packet state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            pid_q     <= 8'h00;
            pid_err_q <= 1'b0;
            len_q     <= 1'b0;
            field_q   <= 11'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pid_q     <= pid_d;
            pid_err_q <= pid_err_d;
            len_q     <= len_d;
            field_q   <= field_d;
        end
    end

    // Result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_valid_q   <= 1'b0;
            tok_pid_q     <= 4'h0;
            tok_field_q   <= 11'd0;
            tok_match_q   <= 1'b0;
            tok_crc_err_q <= 1'b0;
            tok_pid_err_q <= 1'b0;
            tok_len_err_q <= 1'b0;
        end else begin
            tok_valid_q   <= tok_valid_d;
            tok_pid_q     <= tok_pid_d;
            tok_field_q   <= tok_field_d;
            tok_match_q   <= tok_match_d;
            tok_crc_err_q <= tok_crc_err_d;
            tok_pid_err_q <= tok_pid_err_d;
            tok_len_err_q <= tok_len_err_d;
        end
    end

    assign tok_valid   = tok_valid_q;
    assign tok_pid     = tok_pid_q;
    assign tok_addr    = tok_field_q[6:0];
    assign tok_endp    = tok_field_q[10:7];
    assign tok_frame   = tok_field_q;
    assign tok_match   = tok_match_q;
    assign tok_crc_err = tok_crc_err_q;
    assign tok_pid_err = tok_pid_err_q;
    assign tok_len_err = tok_len_err_q;

endmodule

// File: tb/tb_usbls_rx_token_decoder.sv
// Bench for usbls_rx_token_decoder: directed token packets followed by
// randomized packets, each checked against a packet-level reference model.
module tb_usbls_rx_token_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_sop = 1'b0;
    logic        rx_bit_valid = 1'b0;
    logic        rx_bit = 1'b0;
    logic        rx_eop = 1'b0;
    logic [6:0]  dev_addr = 7'h00;
    logic        tok_valid;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic [10:0] tok_frame;
    logic        tok_match;
    logic        tok_crc_err;
    logic        tok_pid_err;
    logic        tok_len_err;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int exp_pulses = 0;

    // Packet under construction for the model.
    logic [7:0] m_pid;
    bit         body[$];

    // Expected result and last published result.
    bit          exp_emit;
    logic [3:0]  exp_pid;
    logic [10:0] exp_field;
    logic        exp_match, exp_crc, exp_perr, exp_len;
    logic [3:0]  last_pid = 4'h0;
    logic [10:0] last_field = 11'd0;

    usbls_rx_token_decoder #(.ADDR_FILTER(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_sop(rx_sop), .rx_bit_valid(rx_bit_valid),
        .rx_bit(rx_bit), .rx_eop(rx_eop), .dev_addr(dev_addr),
        .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_addr(tok_addr),
        .tok_endp(tok_endp), .tok_frame(tok_frame), .tok_match(tok_match),
        .tok_crc_err(tok_crc_err), .tok_pid_err(tok_pid_err), .tok_len_err(tok_len_err)
    );

    always #5 clk = ~clk;

    // Count result pulses independently of the per-packet checks.
    always @(negedge clk) begin
        if (tok_valid) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC5 bits to transmit for an 11-bit field: complemented remainder.
    function automatic logic [4:0] ref_crc(input logic [10:0] f);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            c = (c[4] ^ f[i]) ? ({c[3:0], 1'b0} ^ 5'b00101) : {c[3:0], 1'b0};
        end
        return ~c;
    endfunction

    function automatic bit is_tok(input logic [3:0] n);
        return (n == 4'h1) || (n == 4'h9) || (n == 4'hD) || (n == 4'h5);
    endfunction

    // Token packet: field LSB-first, then CRC MSB-first, trimmed/padded to nbody.
    task automatic build(input logic [7:0] pid, input logic [10:0] f, input logic [4:0] crc, input int nbody);
        m_pid = pid;
        body.delete();
        for (int i = 0; i < 11; i++) body.push_back(f[i]);
        for (int i = 0; i < 5; i++) body.push_back(crc[4-i]);
        while (body.size() > nbody) void'(body.pop_back());
        while (body.size() < nbody) body.push_back(bit'($urandom_range(0, 1)));
    endtask

    task automatic compute_expect();
        logic [4:0] rx_crc;
        int n;
        n = body.size();
        exp_emit  = is_tok(m_pid[3:0]);
        exp_pid   = m_pid[3:0];
        exp_perr  = (m_pid[7:4] != ~m_pid[3:0]);
        exp_field = 11'd0;
        for (int i = 0; i < 11 && i < n; i++) exp_field[i] = body[i];
        rx_crc = 5'd0;
        if (n == 16) for (int i = 0; i < 5; i++) rx_crc = {rx_crc[3:0], logic'(body[11+i])};
        exp_len   = (n != 16);
        exp_crc   = exp_len || (rx_crc != ref_crc(exp_field));
        exp_match = (exp_field[6:0] == dev_addr);
    endtask

    task automatic send_bit(input bit b, input int gap_max, input bit with_eop);
        repeat ($urandom_range(0, gap_max)) begin
            rx_bit_valid = 1'b0;
            rx_bit = 1'($urandom);
            tick();
        end
        rx_bit_valid = 1'b1;
        rx_bit = b;
        rx_eop = with_eop;
        tick();
        rx_bit_valid = 1'b0;
        rx_eop = 1'b0;
    endtask

    task automatic xmit(input int gap_max, input bit eop_last);
        rx_sop = 1'b1;
        tick();
        rx_sop = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(m_pid[i], gap_max, 1'b0);
        for (int i = 0; i < body.size(); i++)
            send_bit(body[i], gap_max, eop_last && (i == body.size() - 1));
        if (!(eop_last && body.size() > 0)) begin
            rx_eop = 1'b1;
            tick();
            rx_eop = 1'b0;
        end
    endtask

    // Start a packet and leave it unfinished after nbits body bits.
    task automatic partial(input logic [7:0] pid, input int nbits);
        rx_sop = 1'b1;
        tick();
        rx_sop = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(pid[i], 1, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(bit'($urandom_range(0, 1)), 1, 1'b0);
    endtask

    // Called right after the EOP cycle's edge: the result is visible now.
    task automatic verify(input string tag);
        compute_expect();
        if (exp_emit) begin
            chk({tag, ".valid"}, 32'(tok_valid), 32'd1);
            chk({tag, ".pid"}, 32'(tok_pid), 32'(exp_pid));
            chk({tag, ".addr"}, 32'(tok_addr), 32'(exp_field[6:0]));
            chk({tag, ".endp"}, 32'(tok_endp), 32'(exp_field[10:7]));
            chk({tag, ".frame"}, 32'(tok_frame), 32'(exp_field));
            chk({tag, ".match"}, 32'(tok_match), 32'(exp_match));
            chk({tag, ".crc_err"}, 32'(tok_crc_err), 32'(exp_crc));
            chk({tag, ".pid_err"}, 32'(tok_pid_err), 32'(exp_perr));
            chk({tag, ".len_err"}, 32'(tok_len_err), 32'(exp_len));
            last_pid = exp_pid;
            last_field = exp_field;
            exp_pulses++;
        end else begin
            chk({tag, ".novalid"}, 32'(tok_valid), 32'd0);
            chk({tag, ".hold_frame"}, 32'(tok_frame), 32'(last_field));
            chk({tag, ".hold_pid"}, 32'(tok_pid), 32'(last_pid));
        end
        tick();
        chk({tag, ".pulse_end"}, 32'(tok_valid), 32'd0);
        chk({tag, ".pulses"}, 32'(pulse_cnt), 32'(exp_pulses));
    endtask

    initial begin
        logic [3:0] toks [4];
        logic [3:0] nib;
        logic [10:0] f;
        int kind;
        toks[0] = 4'h1; toks[1] = 4'h9; toks[2] = 4'hD; toks[3] = 4'h5;

        // Reset state.
        repeat (3) tick();
        chk("reset.valid", 32'(tok_valid), 32'd0);
        chk("reset.frame", 32'(tok_frame), 32'd0);
        chk("reset.pid", 32'(tok_pid), 32'd0);
        chk("reset.errs", 32'({tok_match, tok_crc_err, tok_pid_err, tok_len_err}), 32'd0);
        rst_n = 1'b1;
        tick();

        // SETUP addr 0 endp 0 from the literal bytes 2D 00 10.
        m_pid = 8'h2D;
        body.delete();
        for (int i = 0; i < 8; i++) body.push_back(1'b0);
        for (int i = 0; i < 8; i++) body.push_back(i == 4);
        xmit(0, 1'b0);
        chk("setup0.crc_lit", 32'(tok_crc_err), 32'd0);
        verify("setup0");

        // Same packet with CRC 5'h03.
        build(8'h2D, 11'd0, 5'h03, 16);
        xmit(0, 1'b0);
        verify("setup_badcrc");

        // IN addr 15 endp E, matching then non-matching device address.
        f = {4'hE, 7'h15};
        dev_addr = 7'h15;
        build(8'h69, f, ref_crc(f), 16);
        xmit(1, 1'b0);
        chk("in.match_lit", 32'(tok_match), 32'd1);
        verify("in_match");
        dev_addr = 7'h14;
        xmit(1, 1'b0);
        chk("in.nomatch_lit", 32'(tok_match), 32'd0);
        verify("in_nomatch");

        // SOF frame 0x710.
        build(8'hA5, 11'h710, ref_crc(11'h710), 16);
        xmit(0, 1'b0);
        chk("sof.frame_lit", 32'(tok_frame), 32'h710);
        verify("sof");

        // PID 2C: complement wrong and nibble C is not a token, so dropped.
        build(8'h2C, 11'h123, ref_crc(11'h123), 16);
        xmit(0, 1'b0);
        verify("pid2c");
        // Bad complement on a token nibble, short and long bodies.
        build(8'h3D, 11'h0AA, ref_crc(11'h0AA), 15);
        xmit(0, 1'b0);
        verify("perr_len15");
        build(8'h3D, 11'h0AA, ref_crc(11'h0AA), 17);
        xmit(0, 1'b0);
        verify("perr_len17");

        // DATA0 packet: nothing published.
        build(8'hC3, 11'h5A5, 5'h0F, 24);
        xmit(1, 1'b0);
        verify("data0");

        // Restart mid-token, then a good token must decode.
        partial(8'h2D, 6);
        build(8'hE1, 11'h2B7, ref_crc(11'h2B7), 16);
        xmit(0, 1'b0);
        verify("after_abort");

        // Reset in the middle of a body.
        partial(8'h69, 9);
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", 32'(tok_valid), 32'd0);
        chk("midrst.frame", 32'(tok_frame), 32'd0);
        tick();
        rst_n = 1'b1;
        last_pid = 4'h0;
        last_field = 11'd0;
        tick();
        chk("midrst.pulses", 32'(pulse_cnt), 32'(exp_pulses));
        build(8'h2D, 11'h3C1, ref_crc(11'h3C1), 16);
        xmit(0, 1'b0);
        verify("after_reset");

        // EOP in the same cycle as the last CRC bit.
        build(8'h69, 11'h4D2, ref_crc(11'h4D2), 16);
        xmit(0, 1'b1);
        verify("eop_on_last");

        // Randomized packets.
        for (int k = 0; k < 80; k++) begin
            kind = $urandom_range(0, 5);
            nib = toks[$urandom_range(0, 3)];
            f = 11'($urandom);
            dev_addr = ($urandom_range(0, 1) == 1) ? f[6:0] : 7'($urandom);
            case (kind)
                0, 1: build({~nib, nib}, f, ref_crc(f), 16);
                2: build({~nib, nib}, f, ref_crc(f) ^ 5'(1 << $urandom_range(0, 4)), 16);
                3: build({~nib ^ 4'($urandom_range(1, 15)), nib}, f, ref_crc(f), 16);
                4: begin
                    nib = 4'($urandom);
                    while (is_tok(nib)) nib = 4'($urandom);
                    build({~nib, nib}, f, 5'($urandom), $urandom_range(0, 20));
                end
                default: build({~nib, nib}, f, ref_crc(f), $urandom_range(0, 20));
            endcase
            if ($urandom_range(0, 4) == 0) partial({~nib, nib}, $urandom_range(0, 18));
            xmit($urandom_range(0, 2), bit'($urandom_range(0, 1)));
            verify("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
